experiment_plant_emulator: RTL

Synthesizable hardware-in-the-loop model of the experiment plant that drives `fsm_experiment` from the other side of its interface. It generates the fast-gate opto pulse train and the phase reference. It answers `detonation_signal` with a bouncing wire-sensor waveform and answers `output_trigger` with a detector busy window. It sits on the board in place of the real optics, wire sensor and detector, so the full trigger chain can be exercised without hardware.

---
 rtl/plant_emu_pkg.sv | 27 ++
 rtl/plant_timer.sv | 30 +++
 rtl/experiment_plant_emulator.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plant_emu_pkg.sv
// rtl/plant_emu_pkg.sv - shared states, LFSR constant and bounce helpers for the plant emulator
package plant_emu_pkg;

  typedef enum logic [2:0] {FG_IDLE, FG_WAIT, FG_HIGH, FG_LOW, FG_DONE} fg_state_t;
  typedef enum logic [2:0] {W_IDLE, W_DELAY, W_BOUNCE, W_SETTLE, W_HOLD} wire_state_t;
  typedef enum logic [1:0] {D_READY, D_DELAY, D_BUSY} det_state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] lfsr);
    return {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  endfunction

  // Low nibble folded into 0..9 so the interval spans 1..10 units
  function automatic int unsigned bounce_interval(input logic [15:0] lfsr, input int unsigned unit);
    logic [3:0] r;
    r = lfsr[3:0];
    if (r > 4'd9) r = r - 4'd6;
    return unit * (32'd1 + {28'd0, r});
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/plant_timer.sv
// rtl/plant_timer.sv - loadable down-counter that pulses done on its last counted cycle
module plant_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  // Reload on request, otherwise count down and park at zero
  always_comb begin
    count_d = count_q;
    if (load) count_d = value;
    else if (count_q != '0) count_d = count_q - 1'b1;
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // A phase loaded with N therefore lasts exactly N cycles
  assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/experiment_plant_emulator.sv
// rtl/experiment_plant_emulator.sv - fast-gate, phase, wire-sensor and detector emulation
module experiment_plant_emulator
  import plant_emu_pkg::*;
#(
  parameter int unsigned FG_START_CYC    = 1_000_000,
  parameter int unsigned FG_PERIOD_CYC   = 2_000_000,
  parameter int unsigned FG_OPEN_CYC     = 20_000,
  parameter int unsigned FG_PULSES       = 10,
  parameter int unsigned PHASE_HALF_CYC  = 1_000,
  parameter int unsigned WIRE_DELAY_CYC  = 1_000,
  parameter int unsigned BOUNCE_EDGES    = 10,
  parameter int unsigned BOUNCE_UNIT_CYC = 2,
  parameter int unsigned WIRE_SETTLE_CYC = 20,
  parameter int unsigned WIRE_HOLD_CYC   = 200_000,
  parameter int unsigned DET_DELAY_CYC   = 40,
  parameter int unsigned DET_BUSY_CYC    = 1_280_000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       detonation_signal,
  input  logic       output_trigger,
  output logic       fg_signal,
  output logic       phase_signal,
  output logic       wire_signal,
  output logic       detector_ready,
  output logic [7:0] fg_count,
  output logic       wire_busy
);

  localparam int FG_W = $clog2(max_u(FG_START_CYC, FG_PERIOD_CYC)) + 1;
  localparam int PH_W = $clog2(PHASE_HALF_CYC) + 1;
  localparam int WT_W = $clog2(max_u(max_u(WIRE_DELAY_CYC, BOUNCE_UNIT_CYC * 10),
                                     max_u(WIRE_SETTLE_CYC, WIRE_HOLD_CYC))) + 1;
  localparam int DT_W = $clog2(max_u(DET_DELAY_CYC, DET_BUSY_CYC)) + 1;
  localparam int EG_W = $clog2(BOUNCE_EDGES) + 1;

  // ---------------- edge detection ----------------
  logic det_prev_q, det_prev_d, trig_prev_q, trig_prev_d, armed_q, armed_d;
  logic det_edge, trig_edge;

  // armed_q masks the first cycle after reset so a held-high input is not seen as an edge
  always_comb begin
    det_prev_d  = detonation_signal;
    trig_prev_d = output_trigger;
    armed_d     = 1'b1;
  end

  // Edge history registers
  always_ff @(posedge clock) begin
    if (reset) begin
      det_prev_q  <= 1'b0;
      trig_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      det_prev_q  <= det_prev_d;
      trig_prev_q <= trig_prev_d;
      armed_q     <= armed_d;
    end
  end

  assign det_edge  = armed_q & detonation_signal & ~det_prev_q;
  assign trig_edge = armed_q & output_trigger & ~trig_prev_q;

  // ---------------- fast gate ----------------
  fg_state_t         fg_state_q, fg_state_d;
  logic              fg_q, fg_d;
  logic [7:0]        fg_count_q, fg_count_d;
  logic              fg_load, fg_done;
  logic [FG_W-1:0]   fg_value;

  // Pulse train sequencing; dropping enable aborts from any state
  always_comb begin
    fg_state_d = fg_state_q;
    fg_d       = fg_q;
    fg_count_d = fg_count_q;
    fg_load    = 1'b0;
    fg_value   = '0;
    if (!enable) begin
      fg_state_d = FG_IDLE;
      fg_d       = 1'b0;
      fg_count_d = 8'd0;
    end else begin
      case (fg_state_q)
        FG_IDLE: begin
          fg_state_d = FG_WAIT;
          fg_load    = 1'b1;
          fg_value   = FG_W'(FG_START_CYC);
        end
        FG_WAIT, FG_LOW: begin
          if (fg_done) begin
            fg_state_d = FG_HIGH;
            fg_d       = 1'b1;
            fg_count_d = (fg_count_q == 8'hFF) ? 8'hFF : fg_count_q + 8'd1;
            fg_load    = 1'b1;
            fg_value   = FG_W'(FG_OPEN_CYC);
          end
        end
        FG_HIGH: begin
          if (fg_done) begin
            fg_d = 1'b0;
            if (FG_PULSES != 32'd0 && {24'd0, fg_count_q} >= FG_PULSES) begin
              fg_state_d = FG_DONE;
            end else begin
              fg_state_d = FG_LOW;
              fg_load    = 1'b1;
              fg_value   = FG_W'(FG_PERIOD_CYC - FG_OPEN_CYC);
            end
          end
        end
        FG_DONE: fg_state_d = FG_DONE;
        default: fg_state_d = FG_IDLE;
      endcase
    end
  end

  plant_timer #(.WIDTH(FG_W)) u_fg_timer (
    .clock(clock), .reset(reset), .load(fg_load), .value(fg_value), .done(fg_done)
  );

  // ---------------- phase reference ----------------
  logic            phase_q, phase_d, ph_run_q, ph_run_d, ph_load, ph_done;
  logic [PH_W-1:0] ph_value;

  // Square wave while enabled; disabled state reloads zero to keep the counter cleared
  always_comb begin
    phase_d  = phase_q;
    ph_run_d = ph_run_q;
    ph_load  = 1'b0;
    ph_value = PH_W'(PHASE_HALF_CYC);
    if (!enable) begin
      phase_d  = 1'b0;
      ph_run_d = 1'b0;
      ph_load  = 1'b1;
      ph_value = '0;
    end else if (!ph_run_q) begin
      ph_run_d = 1'b1;
      ph_load  = 1'b1;
    end else if (ph_done) begin
      phase_d = ~phase_q;
      ph_load = 1'b1;
    end
  end

  plant_timer #(.WIDTH(PH_W)) u_ph_timer (
    .clock(clock), .reset(reset), .load(ph_load), .value(ph_value), .done(ph_done)
  );

  // ---------------- wire sensor ----------------
  wire_state_t     w_state_q, w_state_d;
  logic            wire_q, wire_d, wire_busy_q, wire_busy_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [EG_W-1:0] edges_q, edges_d;
  logic            w_load, w_done;
  logic [WT_W-1:0] w_value;

  // Delay, LFSR-timed bounce, settle and hold; each interval load advances the LFSR once
  always_comb begin
    w_state_d = w_state_q;
    wire_d    = wire_q;
    lfsr_d    = lfsr_q;
    edges_d   = edges_q;
    w_load    = 1'b0;
    w_value   = '0;
    case (w_state_q)
      W_IDLE: begin
        if (det_edge) begin
          w_state_d = W_DELAY;
          w_load    = 1'b1;
          w_value   = WT_W'(WIRE_DELAY_CYC);
        end
      end
      W_DELAY: begin
        if (w_done) begin
          w_state_d = W_BOUNCE;
          wire_d    = 1'b1;
          edges_d   = '0;
          w_load    = 1'b1;
          w_value   = WT_W'(bounce_interval(lfsr_q, BOUNCE_UNIT_CYC));
          lfsr_d    = lfsr_next(lfsr_q);
        end
      end
      W_BOUNCE: begin
        if (w_done) begin
          wire_d  = ~wire_q;
          edges_d = edges_q + 1'b1;
          w_load  = 1'b1;
          if (edges_q == EG_W'(BOUNCE_EDGES - 1)) begin
            w_state_d = W_SETTLE;
            w_value   = WT_W'(WIRE_SETTLE_CYC);
          end else begin
            w_value = WT_W'(bounce_interval(lfsr_q, BOUNCE_UNIT_CYC));
            lfsr_d  = lfsr_next(lfsr_q);
          end
        end
      end
      W_SETTLE: begin
        if (w_done) begin
          w_state_d = W_HOLD;
          wire_d    = 1'b1;
          w_load    = 1'b1;
          w_value   = WT_W'(WIRE_HOLD_CYC);
        end
      end
      W_HOLD: begin
        if (w_done) begin
          w_state_d = W_IDLE;
          wire_d    = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    wire_busy_d = (w_state_d != W_IDLE);
  end

  plant_timer #(.WIDTH(WT_W)) u_wire_timer (
    .clock(clock), .reset(reset), .load(w_load), .value(w_value), .done(w_done)
  );

  // ---------------- detector ----------------
  det_state_t      d_state_q, d_state_d;
  logic            ready_q, ready_d, d_load, d_done;
  logic [DT_W-1:0] d_value;

  // Trigger-to-busy delay followed by the busy window
  always_comb begin
    d_state_d = d_state_q;
    ready_d   = ready_q;
    d_load    = 1'b0;
    d_value   = '0;
    case (d_state_q)
      D_READY: begin
        if (trig_edge) begin
          d_state_d = D_DELAY;
          d_load    = 1'b1;
          d_value   = DT_W'(DET_DELAY_CYC);
        end
      end
      D_DELAY: begin
        if (d_done) begin
          d_state_d = D_BUSY;
          ready_d   = 1'b0;
          d_load    = 1'b1;
          d_value   = DT_W'(DET_BUSY_CYC);
        end
      end
      D_BUSY: begin
        if (d_done) begin
          d_state_d = D_READY;
          ready_d   = 1'b1;
        end
      end
      default: d_state_d = D_READY;
    endcase
  end

  plant_timer #(.WIDTH(DT_W)) u_det_timer (
    .clock(clock), .reset(reset), .load(d_load), .value(d_value), .done(d_done)
  );

  // State and registered outputs for all generators
  always_ff @(posedge clock) begin
    if (reset) begin
      fg_state_q  <= FG_IDLE;
      fg_q        <= 1'b0;
      fg_count_q  <= 8'd0;
      phase_q     <= 1'b0;
      ph_run_q    <= 1'b0;
      w_state_q   <= W_IDLE;
      wire_q      <= 1'b0;
      wire_busy_q <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      edges_q     <= '0;
      d_state_q   <= D_READY;
      ready_q     <= 1'b1;
    end else begin
      fg_state_q  <= fg_state_d;
      fg_q        <= fg_d;
      fg_count_q  <= fg_count_d;
      phase_q     <= phase_d;
      ph_run_q    <= ph_run_d;
      w_state_q   <= w_state_d;
      wire_q      <= wire_d;
      wire_busy_q <= wire_busy_d;
      lfsr_q      <= lfsr_d;
      edges_q     <= edges_d;
      d_state_q   <= d_state_d;
      ready_q     <= ready_d;
    end
  end

  assign fg_signal      = fg_q;
  assign fg_count       = fg_count_q;
  assign phase_signal   = phase_q;
  assign wire_signal    = wire_q;
  assign wire_busy      = wire_busy_q;
  assign detector_ready = ready_q;

endmodule
